// File: rtl/divider_4bit_seq_if.sv
// Handshake and operand/result bundle for divider_4bit_seq.
// The master side drives start and the operands. The slave side returns the results and status.
interface divider_4bit_seq_if;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/divider_4bit_seq.sv
// Sequential 4-bit unsigned restoring divider that produces one quotient bit per clock.
// Optional macro DIVIDER_4BIT_SEQ_FAST_EXIT_EN finishes early when divisor > dividend.
//
// state  | meaning
// IDLE   | waiting for an accepted start
// RUN    | four shift/trial-subtract steps, step counts 3 down to 0
// DONE   | done pulse is high, then the FSM returns to IDLE
module divider_4bit_seq (
  input  logic                  clk,
  input  logic                  rst,
  divider_4bit_seq_if.slave     bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t     state;
  logic [4:0] a_reg;
  logic [3:0] q_reg;
  logic [3:0] m_reg;
  logic [1:0] step;

  logic [5:0] shifted;
  logic [5:0] trial;
  logic       borrow;
  logic [4:0] a_next;
  logic [3:0] q_next;
  logic       fast_exit;

  // A stays below M, so the top bit of shifted is always 0. It is carried through so that the borrow is exact.
  always_comb begin
    shifted = {a_reg, q_reg[3]};
    trial   = shifted - {2'b00, m_reg};
    borrow  = trial[5];
    a_next  = borrow ? shifted[4:0] : trial[4:0];
    q_next  = {q_reg[2:0], ~borrow};
  end

`ifdef DIVIDER_4BIT_SEQ_FAST_EXIT_EN
  assign fast_exit = (bus.divisor > bus.dividend);
`else
  assign fast_exit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      a_reg           <= '0;
      q_reg           <= '0;
      m_reg           <= '0;
      step            <= '0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            if (bus.divisor == 4'd0) begin
              bus.quotient    <= 4'hF;
              bus.remainder   <= bus.dividend;
              bus.div_by_zero <= 1'b1;
              bus.done        <= 1'b1;
              bus.busy        <= 1'b0;
              state           <= S_DONE;
            end else if (fast_exit) begin
              bus.quotient    <= 4'd0;
              bus.remainder   <= bus.dividend;
              bus.div_by_zero <= 1'b0;
              bus.done        <= 1'b1;
              bus.busy        <= 1'b0;
              state           <= S_DONE;
            end else begin
              m_reg           <= bus.divisor;
              q_reg           <= bus.dividend;
              a_reg           <= '0;
              step            <= 2'd3;
              bus.busy        <= 1'b1;
              bus.div_by_zero <= 1'b0;
              state           <= S_RUN;
            end
          end
        end
        S_RUN: begin
          a_reg <= a_next;
          q_reg <= q_next;
          step  <= step - 2'd1;
          if (step == 2'd0) begin
            bus.quotient  <= q_next;
            bus.remainder <= a_next[3:0];
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            state         <= S_DONE;
          end
        end
        S_DONE: begin
          bus.done <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_4bit_seq.sv
// Directed bench for divider_4bit_seq. Expected results are queued when each operation is
// driven, then popped and compared when done pulses.
module tb_divider_4bit_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  divider_4bit_seq_if bus ();

  divider_4bit_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit hold);
    exp_t e;
    exp_t got;
    int   n;
    bit   seen;
    e.dbz = (b == 4'd0);
    e.q   = (b == 4'd0) ? 4'hF : a / b;
    e.r   = (b == 4'd0) ? a : a % b;
    e.lat = (b == 4'd0) ? 0 : 4;
`ifdef DIVIDER_4BIT_SEQ_FAST_EXIT_EN
    if (b > a) e.lat = 0;
`endif
    sb.push_back(e);

    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      bus.dividend = 4'd1;
      bus.divisor  = 4'd1;
    end else begin
      bus.start = 1'b0;
    end

    seen = 1'b0;
    for (n = 0; n < 20; n++) begin
      if (n > 0) @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      check($sformatf("busy_run_%0d_%0d_c%0d", a, b, n), {31'd0, bus.busy}, 32'd1);
    end
    bus.start = 1'b0;
    check($sformatf("done_seen_%0d_%0d", a, b), {31'd0, seen}, 32'd1);

    if (seen) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 32'd0, 32'd1);
      end else begin
        got = sb.pop_front();
        check($sformatf("latency_%0d_%0d", a, b), n, got.lat);
        check($sformatf("busy_at_done_%0d_%0d", a, b), {31'd0, bus.busy}, 32'd0);
        check($sformatf("quotient_%0d_%0d", a, b), {28'd0, bus.quotient}, {28'd0, got.q});
        check($sformatf("remainder_%0d_%0d", a, b), {28'd0, bus.remainder}, {28'd0, got.r});
        check($sformatf("dbz_%0d_%0d", a, b), {31'd0, bus.div_by_zero}, {31'd0, got.dbz});
      end
    end

    @(negedge clk);
    check($sformatf("done_pulse_%0d_%0d", a, b), {31'd0, bus.done}, 32'd0);
    check($sformatf("busy_after_%0d_%0d", a, b), {31'd0, bus.busy}, 32'd0);
    check($sformatf("quotient_held_%0d_%0d", a, b), {28'd0, bus.quotient}, {28'd0, e.q});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit any_activity;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = 4'd0;
    bus.divisor  = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_quotient", {28'd0, bus.quotient}, 32'd0);
    check("rst_remainder", {28'd0, bus.remainder}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    rst = 1'b0;

    any_activity = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) any_activity = 1'b1;
    end
    check("idle_quiet", {31'd0, any_activity}, 32'd0);

    run_op(4'd9, 4'd3, 1'b0);
    run_op(4'd5, 4'd5, 1'b0);
    run_op(4'd12, 4'd6, 1'b0);
    run_op(4'd15, 4'd4, 1'b0);
    run_op(4'd7, 4'd9, 1'b0);
    run_op(4'd15, 4'd0, 1'b0);
    run_op(4'd8, 4'd2, 1'b0);
    run_op(4'd9, 4'd3, 1'b1);
    run_op(4'd6, 4'd4, 1'b0);
    run_op(4'd14, 4'd3, 1'b0);

    // Abort 13/2 partway through. The outputs must clear at once and no done pulse may follow.
    bus.start    = 1'b1;
    bus.dividend = 4'd13;
    bus.divisor  = 4'd2;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_quotient", {28'd0, bus.quotient}, 32'd0);
    check("midrst_remainder", {28'd0, bus.remainder}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    any_activity = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) any_activity = 1'b1;
    end
    check("midrst_no_done", {31'd0, any_activity}, 32'd0);

    run_op(4'd13, 4'd2, 1'b0);

    check("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
